// File: rtl/fifo_rd_drain.sv
// -----------------------------------------------------------------------------
// fifo_rd_drain
//
// Read-side consumer for the asynchronous FIFO. It lives entirely in the read
// clock domain. It pops words from the FIFO read port into a 2-entry skid
// buffer and presents them downstream on a valid/ready stream. It also counts
// every pop.
//
// Parameters
//   DSIZE      data width (matches the FIFO data width)
//   CNT_W      width of the wrapping pop counter
//
// Ports
//   rclk       in   read-domain clock, rising edge
//   rrst_n     in   asynchronous active-low reset
//   rdata      in   FIFO head word, valid whenever rempty=0
//   rempty     in   FIFO empty flag, already synchronised to rclk
//   rinc       out  FIFO pop strobe; the head word is consumed on the edge
//   en         in   drain enable; 0 stops new pops
//   out_data   out  downstream data (buffer head)
//   out_valid  out  buffer holds at least one word
//   out_ready  in   downstream accepts on an edge with out_valid & out_ready
//   pop_count  out  FIFO pops since reset, wraps silently
// -----------------------------------------------------------------------------
module fifo_rd_drain #(
  parameter int DSIZE = 8,
  parameter int CNT_W = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  input  logic             en,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pop_count
);

  // Buffer occupancy. It is kept as an explicit three-state machine so that
  // an illegal count cannot be encoded by accident.
  typedef enum logic [1:0] {
    OCC_0 = 2'd0,
    OCC_1 = 2'd1,
    OCC_2 = 2'd2
  } occ_e;

  occ_e             r_occ;
  occ_e             w_occ_nxt;
  logic             r_head;
  logic             r_tail;
  logic [DSIZE-1:0] r_buf [2];
  logic             r_out_valid;
  logic [CNT_W-1:0] r_pop_count;

  logic             w_push;
  logic             w_drain;
  logic             w_has_space;

  // ---------------------------------------------------------------------------
  // Pop rule.
  // The pop strobe looks only at registered occupancy and never at out_ready.
  // This keeps the downstream ready off the combinational path to the FIFO.
  // The strobe does not depend on rdata, so an X on rdata while the FIFO is
  // empty cannot reach rinc. The rrst_n term forces rinc low during reset.
  // ---------------------------------------------------------------------------
  assign w_has_space = (r_occ != OCC_2);
  assign rinc        = en & ~rempty & w_has_space & rrst_n;

  assign w_push  = rinc;
  assign w_drain = r_out_valid & out_ready;

  // ---------------------------------------------------------------------------
  // Occupancy next-state
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    w_occ_nxt = r_occ;
    unique case ({w_push, w_drain})
      2'b10: begin
        unique case (r_occ)
          OCC_0:   w_occ_nxt = OCC_1;
          OCC_1:   w_occ_nxt = OCC_2;
          default: w_occ_nxt = r_occ;   // push is blocked at OCC_2
        endcase
      end
      2'b01: begin
        unique case (r_occ)
          OCC_2:   w_occ_nxt = OCC_1;
          OCC_1:   w_occ_nxt = OCC_0;
          default: w_occ_nxt = r_occ;   // no drain at OCC_0 (out_valid=0)
        endcase
      end
      default: w_occ_nxt = r_occ;       // idle, or push and drain together
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, pointers and the registered valid flag
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge, whatever the order of the processes.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_occ       <= OCC_0;
      r_out_valid <= 1'b0;
      r_head      <= 1'b0;
      r_tail      <= 1'b0;
    end else begin
      r_occ       <= w_occ_nxt;
      r_out_valid <= (w_occ_nxt != OCC_0);
      if (w_push)  r_tail <= ~r_tail;
      if (w_drain) r_head <= ~r_head;
    end
  end

  // ---------------------------------------------------------------------------
  // Skid buffer storage
  // ---------------------------------------------------------------------------
  // NOTE: the buffer has only two entries and out_data must read 0 during
  // reset, so the storage is reset. A larger memory would not be reset.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_buf[0] <= '0;
      r_buf[1] <= '0;
    end else if (w_push) begin
      r_buf[r_tail] <= rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Pop counter: wraps modulo 2^CNT_W with no saturation or flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_pop_count <= '0;
    end else if (w_push) begin
      r_pop_count <= r_pop_count + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid = r_out_valid;
  assign out_data  = r_buf[r_head];
  assign pop_count = r_pop_count;

endmodule

// File: doc/fifo_rd_drain.md
Name: fifo_rd_drain

Overview:
- Read-side consumer for the team's asynchronous FIFO, living entirely in the read clock domain.
- Pops words from the FIFO read port (rdata/rempty/rinc) whenever it has space.
- Presents the words downstream on a valid/ready stream through a 2-entry skid buffer.
- Counts drained words, and never issues a read against an empty FIFO.

Parameters:
- DSIZE, 8: data width; matches the FIFO `DSIZE.
- CNT_W, 16: width of the pop counter.

Ports:
- rclk  input  1  read-domain clock; all logic on its rising edge.
- rrst_n  input  1  asynchronous, active-low reset.
- rdata  input  DSIZE  FIFO head word; combinationally valid whenever rempty=0.
- rempty  input  1  FIFO empty flag, already synchronised to rclk.
- rinc  output  1  FIFO pop strobe; the head word is consumed at the rclk edge where rinc=1.
- en  input  1  drain enable; 0 stops new pops.
- out_data  output  DSIZE  downstream data, taken from the buffer head.
- out_valid  output  1  buffer holds at least one word.
- out_ready  input  1  downstream accepts the word on an edge with out_valid=1 and out_ready=1.
- pop_count  output  CNT_W  total FIFO pops since reset.

Behaviour:
- Reset: rrst_n is asynchronous and active-low. While it is low:
  - rinc=0 combinationally.
  - Buffer occupancy occ=0; out_valid=0; out_data=0; pop_count=0.
  - Head/tail pointers are cleared.
- Buffered words are discarded on reset; reset mid-transfer loses them by design.
- Pop rule, combinational: rinc = en & ~rempty & (occ != 2) & rrst_n.
  - Depends only on registered occ, never on out_ready. This gives no comb path from out_ready to rinc.
- Capture: on an edge with rinc=1, rdata is written to buf[tail], tail toggles, and occ increments.
- Drain: on an edge with out_valid & out_ready, head toggles and occ decrements.
- Simultaneous push and drain on the same edge: occ unchanged, both pointers toggle.
- occ range is 0..2 and never overflows or underflows. occ=2 blocks pops. A drain with occ=0 is impossible because out_valid=0.
- Outputs:
  - out_valid = (occ != 0), registered.
  - out_data = buf[head], stable while out_valid=1 and out_ready=0.
- Latency: a word popped at edge k appears with out_valid=1 after edge k (one cycle).
- Throughput: with out_ready held at 1 and the FIFO non-empty, one word per rclk and occ settles at 1.
- Backpressure: with out_ready=0, at most two more pops occur, then rinc stays low.
- Ordering: strict FIFO order. No word is duplicated or dropped.
- en=0 mid-stream: rinc drops the same cycle, and buffered words continue to drain normally.
- rempty rising: rinc drops the same cycle with no read issued against an empty FIFO. This is an assertion in the bench.
- pop_count:
  - Increments by 1 on every edge with rinc=1.
  - Wraps from 2^CNT_W-1 to 0 with no saturation and no flag.
- X-safety: rinc is never X after reset release, even if rdata is X while rempty=1.

Test Plan:
- Reset check: hold rrst_n=0 with rempty=0 and en=1 -> rinc=0, out_valid=0, pop_count=0. Release -> rinc=1 on the first cycle.
- Streaming: FIFO preloaded with 0x01..0x08, out_ready=1, en=1 -> out_data sequence 0x01..0x08 on 8 consecutive cycles; pop_count=8; rinc falls the same cycle rempty rises.
- Backpressure: 5 words in the FIFO, out_ready=0 for 10 cycles -> exactly 2 pops, occ=2, out_data=first word held, pop_count=2. Raise out_ready -> remaining 3 words follow in order with no gap beyond one cycle.
- Enable gating: deassert en after the 3rd pop with 6 words queued -> pops stop at 3, buffered words still drain. Reassert en -> words 4..6 delivered, pop_count=6.
- Random interleave: random winc on the write side, random out_ready at 30% low, 1000 words -> scoreboard order match, zero reads while rempty=1.
- Wrap and reset: CNT_W=4, 17 pops -> pop_count=1. Assert rrst_n low with occ=2 -> out_valid drops immediately, occ=0.
